// File: rtl/sy_ppl_dcache_arb.sv
`default_nettype none
// ============================================================================
// Module   : sy_ppl_dcache_arb
// Purpose  : Shares the single dcache request port among NREQ requesters
//            (0 = LSU, 1 = PTW, 2 = flush sequencer). One transaction is in
//            flight at a time. The arbiter picks a requester round-robin and
//            keeps the grant until the response arrives. Ack, response valid
//            and read data go back to the owning requester only.
// Ports    : clk_i, rst_i         clock, synchronous active-high reset
//            req_*_i              packed per-requester request fields
//            req_kill_i           per-requester abort of its own request
//            req_ack_o            one-hot acceptance back to requester
//            rsp_vld_o            one-hot response valid back to owner
//            rsp_rdata_o          shared response data (valid with rsp_vld_o)
//            dcache_*_o           selected request toward the dcache
//            dcache_kill_o        abort of the accepted in-flight access
//            dcache_ack_i/rsp_*   dcache handshake and response
// Revision : 1.0 - initial release
// ============================================================================
module sy_ppl_dcache_arb #(
  parameter int NREQ = 3,
  parameter int AWTH = 64,
  parameter int DWTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_vld_i,
  input  logic [NREQ*AWTH-1:0]   req_addr_i,
  input  logic [NREQ*DWTH-1:0]   req_wdata_i,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ*DWTH/8-1:0] req_be_i,
  input  logic [NREQ*2-1:0]      req_size_i,
  input  logic [NREQ-1:0]        req_kill_i,
  output logic [NREQ-1:0]        req_ack_o,
  output logic [NREQ-1:0]        rsp_vld_o,
  output logic [DWTH-1:0]        rsp_rdata_o,
  output logic                   dcache_req_o,
  output logic [AWTH-1:0]        dcache_addr_o,
  output logic [DWTH-1:0]        dcache_wdata_o,
  output logic                   dcache_we_o,
  output logic [DWTH/8-1:0]      dcache_be_o,
  output logic [1:0]             dcache_size_o,
  output logic                   dcache_kill_o,
  input  logic                   dcache_ack_i,
  input  logic                   dcache_rsp_vld_i,
  input  logic [DWTH-1:0]        dcache_rdata_i
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = DWTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_nxt_owner;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_nxt_ptr;
  logic            r_rst_q;

  logic            w_blk;
  logic            w_cand_vld;
  logic [PW-1:0]   w_cand;
  logic [PW:0]     w_idx;
  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_owner_inc;
  logic            w_owner_kill;
  logic            w_req;
  logic            w_kill;
  logic [NREQ-1:0] w_ack_vec;
  logic [NREQ-1:0] w_rsp_vec;

  logic [AWTH-1:0] w_addr  [NREQ];
  logic [DWTH-1:0] w_wdata [NREQ];
  logic [BW-1:0]   w_be    [NREQ];
  logic [1:0]      w_size  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr[gi]  = req_addr_i[gi*AWTH +: AWTH];
    assign w_wdata[gi] = req_wdata_i[gi*DWTH +: DWTH];
    assign w_be[gi]    = req_be_i[gi*BW +: BW];
    assign w_size[gi]  = req_size_i[gi*2 +: 2];
  end

  // Outputs stay quiet while reset is held and for one cycle after it.
  assign w_blk = rst_i | r_rst_q;

  // Round-robin scan starting at the priority pointer, wrapping at NREQ.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = '0;
    w_idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) begin
        w_idx = w_idx - (PW+1)'(NREQ);
      end
      if (!w_cand_vld && req_vld_i[w_idx[PW-1:0]] && !req_kill_i[w_idx[PW-1:0]]) begin
        w_cand_vld = 1'b1;
        w_cand     = w_idx[PW-1:0];
      end
    end
  end

  assign w_owner_inc  = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
  assign w_owner_kill = req_kill_i[r_owner];

  // In IDLE the mux follows the candidate so a grant has no extra latency.
  assign w_sel = (r_state == ST_IDLE) ? w_cand : r_owner;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_ptr   = r_ptr;
    w_req       = 1'b0;
    w_kill      = 1'b0;
    w_ack_vec   = '0;
    w_rsp_vec   = '0;
    if (!w_blk) begin
      case (r_state)
        ST_IDLE: begin
          if (w_cand_vld) begin
            w_req       = 1'b1;
            w_nxt_owner = w_cand;
            if (dcache_ack_i) begin
              w_ack_vec[w_cand] = 1'b1;
              w_nxt_state       = ST_WAIT;
            end else begin
              w_nxt_state = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // A kill before acceptance wins over a same-cycle ack and leaves
          // the pointer where it was.
          if (w_owner_kill) begin
            w_nxt_state = ST_IDLE;
          end else begin
            w_req = 1'b1;
            if (dcache_ack_i) begin
              w_ack_vec[r_owner] = 1'b1;
              w_nxt_state        = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_owner_kill) begin
            w_kill      = 1'b1;
            w_nxt_state = ST_IDLE;
            w_nxt_ptr   = w_owner_inc;
          end else if (dcache_rsp_vld_i) begin
            w_rsp_vec[r_owner] = 1'b1;
            w_nxt_state        = ST_IDLE;
            w_nxt_ptr          = w_owner_inc;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    r_rst_q <= rst_i;
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign req_ack_o      = w_ack_vec;
  assign rsp_vld_o      = w_rsp_vec;
  assign rsp_rdata_o    = (|w_rsp_vec) ? dcache_rdata_i : '0;
  assign dcache_req_o   = w_req;
  assign dcache_kill_o  = w_kill;
  assign dcache_addr_o  = w_addr[w_sel];
  assign dcache_wdata_o = w_wdata[w_sel];
  assign dcache_we_o    = w_req & req_we_i[w_sel];
  assign dcache_be_o    = w_be[w_sel];
  assign dcache_size_o  = w_size[w_sel];

`ifndef SYNTHESIS
  a_ack_onehot: assert property (@(posedge clk_i) $onehot0(req_ack_o));
  a_rsp_onehot: assert property (@(posedge clk_i) $onehot0(rsp_vld_o));
  a_owner_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state != ST_IDLE) |=> (r_owner == $past(r_owner)));
  a_no_req_wait: assert property (@(posedge clk_i)
    (r_state == ST_WAIT) |-> !dcache_req_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sy_ppl_dcache_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sy_ppl_dcache_arb
// Purpose  : Self-checking bench for sy_ppl_dcache_arb: a directed vector
//            table, hand-written multi-cycle sequences and a randomized run
//            compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sy_ppl_dcache_arb;

  localparam int NREQ = 3;
  localparam int AWTH = 64;
  localparam int DWTH = 64;
  localparam int BW   = DWTH / 8;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [NREQ-1:0]      req_vld_i, req_we_i, req_kill_i;
  logic [NREQ*AWTH-1:0] req_addr_i;
  logic [NREQ*DWTH-1:0] req_wdata_i;
  logic [NREQ*BW-1:0]   req_be_i;
  logic [NREQ*2-1:0]    req_size_i;
  logic [NREQ-1:0]      req_ack_o, rsp_vld_o;
  logic [DWTH-1:0]      rsp_rdata_o;
  logic                 dcache_req_o, dcache_we_o, dcache_kill_o;
  logic [AWTH-1:0]      dcache_addr_o;
  logic [DWTH-1:0]      dcache_wdata_o;
  logic [BW-1:0]        dcache_be_o;
  logic [1:0]           dcache_size_o;
  logic                 dcache_ack_i, dcache_rsp_vld_i;
  logic [DWTH-1:0]      dcache_rdata_i;

  logic [AWTH-1:0] t_addr  [NREQ];
  logic [DWTH-1:0] t_wdata [NREQ];
  logic [BW-1:0]   t_be    [NREQ];
  logic [1:0]      t_size  [NREQ];
  logic            t_we    [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr_i[i*AWTH +: AWTH]  = t_addr[i];
      req_wdata_i[i*DWTH +: DWTH] = t_wdata[i];
      req_be_i[i*BW +: BW]        = t_be[i];
      req_size_i[i*2 +: 2]        = t_size[i];
      req_we_i[i]                 = t_we[i];
    end
  end

  sy_ppl_dcache_arb #(.NREQ(NREQ), .AWTH(AWTH), .DWTH(DWTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_we_i(req_we_i), .req_be_i(req_be_i), .req_size_i(req_size_i),
    .req_kill_i(req_kill_i), .req_ack_o(req_ack_o), .rsp_vld_o(rsp_vld_o),
    .rsp_rdata_o(rsp_rdata_o), .dcache_req_o(dcache_req_o),
    .dcache_addr_o(dcache_addr_o), .dcache_wdata_o(dcache_wdata_o),
    .dcache_we_o(dcache_we_o), .dcache_be_o(dcache_be_o),
    .dcache_size_o(dcache_size_o), .dcache_kill_o(dcache_kill_o),
    .dcache_ack_i(dcache_ack_i), .dcache_rsp_vld_i(dcache_rsp_vld_i),
    .dcache_rdata_i(dcache_rdata_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: is a transaction open, has it been
  // accepted, who owns it, where the round-robin scan starts.
  bit m_open, m_accepted, m_prev_rst;
  int m_owner, m_ptr;
  bit n_open, n_accepted;
  int n_owner, n_ptr;
  logic [NREQ-1:0] m_ack, m_rsp;
  logic            m_req, m_kill;
  int              m_sel;

  task automatic model_eval();
    m_ack = '0; m_rsp = '0; m_req = 1'b0; m_kill = 1'b0; m_sel = -1;
    n_open = m_open; n_accepted = m_accepted; n_owner = m_owner; n_ptr = m_ptr;
    if (rst_i || m_prev_rst) begin
      // silent
    end else if (!m_open) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (m_sel < 0 && req_vld_i[c] && !req_kill_i[c]) m_sel = c;
      end
      if (m_sel >= 0) begin
        m_req = 1'b1; n_owner = m_sel; n_open = 1'b1;
        if (dcache_ack_i) begin m_ack[m_sel] = 1'b1; n_accepted = 1'b1; end
      end
    end else if (!m_accepted) begin
      if (req_kill_i[m_owner]) n_open = 1'b0;
      else begin
        m_req = 1'b1; m_sel = m_owner;
        if (dcache_ack_i) begin m_ack[m_owner] = 1'b1; n_accepted = 1'b1; end
      end
    end else begin
      if (req_kill_i[m_owner]) begin
        m_kill = 1'b1; n_open = 1'b0; n_ptr = (m_owner + 1) % NREQ;
      end else if (dcache_rsp_vld_i) begin
        m_rsp[m_owner] = 1'b1; n_open = 1'b0; n_ptr = (m_owner + 1) % NREQ;
      end
    end
    if (!n_open) n_accepted = 1'b0;
  endtask

  task automatic model_commit();
    if (rst_i) begin
      m_open = 0; m_accepted = 0; m_owner = 0; m_ptr = 0;
    end else begin
      m_open = n_open; m_accepted = n_accepted; m_owner = n_owner; m_ptr = n_ptr;
    end
    m_prev_rst = rst_i;
  endtask

  task automatic cmp_model();
    chk("model_ack", 64'(req_ack_o), 64'(m_ack));
    chk("model_rsp", 64'(rsp_vld_o), 64'(m_rsp));
    chk("model_req", 64'(dcache_req_o), 64'(m_req));
    chk("model_kill", 64'(dcache_kill_o), 64'(m_kill));
    if (m_req) begin
      chk("model_addr", dcache_addr_o, t_addr[m_sel]);
      chk("model_wdata", dcache_wdata_o, t_wdata[m_sel]);
      chk("model_we", 64'(dcache_we_o), 64'(t_we[m_sel]));
      chk("model_be", 64'(dcache_be_o), 64'(t_be[m_sel]));
      chk("model_size", 64'(dcache_size_o), 64'(t_size[m_sel]));
    end
    if (|m_rsp) chk("model_rdata", rsp_rdata_o, dcache_rdata_i);
  endtask

  // One clock: drive at negedge, check 1 ns later, advance model at posedge.
  task automatic cyc(input logic rst, input logic [2:0] vld, input logic [2:0] kill,
                     input logic ack, input logic rspv, input logic [63:0] rdata,
                     input bit use_exp, input logic [2:0] e_ack, input logic [2:0] e_rsp,
                     input logic e_req, input logic e_kill, input int e_sel, input string tag);
    @(negedge clk);
    rst_i = rst; req_vld_i = vld; req_kill_i = kill;
    dcache_ack_i = ack; dcache_rsp_vld_i = rspv; dcache_rdata_i = rdata;
    model_eval();
    #1;
    cmp_model();
    if (use_exp) begin
      chk({tag, "_ack"}, 64'(req_ack_o), 64'(e_ack));
      chk({tag, "_rsp"}, 64'(rsp_vld_o), 64'(e_rsp));
      chk({tag, "_req"}, 64'(dcache_req_o), 64'(e_req));
      chk({tag, "_kill"}, 64'(dcache_kill_o), 64'(e_kill));
      if (e_req && e_sel >= 0) chk({tag, "_addr"}, dcache_addr_o, t_addr[e_sel]);
      if (|e_rsp) chk({tag, "_rdata"}, rsp_rdata_o, rdata);
    end
    @(posedge clk);
    model_commit();
  endtask

  typedef struct {
    logic [2:0] vld, kill;
    logic       ack, rspv;
    logic [2:0] e_ack, e_rsp;
    logic       e_req, e_kill;
    int         e_sel;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] kill, input logic ack,
                              input logic rspv, input logic [2:0] e_ack, input logic [2:0] e_rsp,
                              input logic e_req, input logic e_kill, input int e_sel);
    vec_t v;
    v.vld = vld; v.kill = kill; v.ack = ack; v.rspv = rspv;
    v.e_ack = e_ack; v.e_rsp = e_rsp; v.e_req = e_req; v.e_kill = e_kill; v.e_sel = e_sel;
    return v;
  endfunction

  task automatic do_reset();
    cyc(1'b1, 3'b111, 3'b000, 1'b1, 1'b1, 64'h0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, -1, "rst");
    cyc(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 64'h0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, -1, "post_rst");
  endtask

  localparam logic [63:0] BEEF = 64'hDEAD_BEEF;

  initial begin
    rst_i = 1'b1; req_vld_i = '0; req_kill_i = '0;
    dcache_ack_i = 1'b0; dcache_rsp_vld_i = 1'b0; dcache_rdata_i = '0;
    m_open = 0; m_accepted = 0; m_owner = 0; m_ptr = 0; m_prev_rst = 0;
    for (int i = 0; i < NREQ; i++) begin
      t_addr[i]  = 64'h8000_0010 + 64'(i) * 64'h100;
      t_wdata[i] = 64'h1111_0000 + 64'(i);
      t_be[i]    = 8'hF0 >> i;
      t_size[i]  = 2'(i + 1);
      t_we[i]    = (i == 2);
    end

    // vld, kill, ack, rspv | e_ack, e_rsp, e_req, e_kill, e_sel
    tbl[0]  = mk(3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 1, 0, 0);   // LSU load, same-cycle ack
    tbl[1]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, -1);  // waiting
    tbl[2]  = mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b001, 0, 0, -1);  // response, ptr -> 1
    tbl[3]  = mk(3'b111, 3'b000, 1, 0, 3'b010, 3'b000, 1, 0, 1);   // rr: 1
    tbl[4]  = mk(3'b101, 3'b000, 0, 1, 3'b000, 3'b010, 0, 0, -1);
    tbl[5]  = mk(3'b111, 3'b000, 1, 0, 3'b100, 3'b000, 1, 0, 2);   // rr: 2
    tbl[6]  = mk(3'b011, 3'b000, 0, 1, 3'b000, 3'b100, 0, 0, -1);
    tbl[7]  = mk(3'b111, 3'b000, 1, 0, 3'b001, 3'b000, 1, 0, 0);   // rr: 0 (wrap)
    tbl[8]  = mk(3'b110, 3'b000, 0, 1, 3'b000, 3'b001, 0, 0, -1);
    tbl[9]  = mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 1, 0, 1);   // PTW, no ack
    tbl[10] = mk(3'b011, 3'b000, 0, 0, 3'b000, 3'b000, 1, 0, 1);   // locked
    tbl[11] = mk(3'b011, 3'b000, 1, 0, 3'b010, 3'b000, 1, 0, 1);
    tbl[12] = mk(3'b001, 3'b001, 0, 1, 3'b000, 3'b010, 0, 0, -1);  // non-owner kill ignored
    tbl[13] = mk(3'b001, 3'b000, 0, 1, 3'b000, 3'b000, 1, 0, 0);   // stray rsp in IDLE
    tbl[14] = mk(3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 1, 0, 0);
    tbl[15] = mk(3'b001, 3'b001, 0, 1, 3'b000, 3'b000, 0, 1, -1);  // kill wins over rsp

    do_reset();
    for (int i = 0; i < 16; i++)
      cyc(1'b0, tbl[i].vld, tbl[i].kill, tbl[i].ack, tbl[i].rspv, BEEF, 1'b1,
          tbl[i].e_ack, tbl[i].e_rsp, tbl[i].e_req, tbl[i].e_kill, tbl[i].e_sel, $sformatf("tbl%0d", i));

    // Locked grant: PTW holds the port for several cycles while LSU waits.
    do_reset();
    cyc(0, 3'b010, 3'b000, 0, 0, BEEF, 1, 3'b000, 3'b000, 1, 0, 1, "lock_g");
    for (int i = 0; i < 4; i++)
      cyc(0, 3'b011, 3'b000, 0, 0, BEEF, 1, 3'b000, 3'b000, 1, 0, 1, "lock_hold");
    cyc(0, 3'b011, 3'b000, 1, 0, BEEF, 1, 3'b010, 3'b000, 1, 0, 1, "lock_ack");
    cyc(0, 3'b001, 3'b000, 0, 1, BEEF, 1, 3'b000, 3'b010, 0, 0, -1, "lock_rsp");
    cyc(0, 3'b001, 3'b000, 1, 0, BEEF, 1, 3'b001, 3'b000, 1, 0, 0, "lock_lsu");
    cyc(0, 3'b000, 3'b000, 0, 1, BEEF, 1, 3'b000, 3'b001, 0, 0, -1, "lock_lrsp");

    // Kill in ISSUE beats a same-cycle ack; pointer stays at 0.
    do_reset();
    cyc(0, 3'b001, 3'b000, 0, 0, BEEF, 1, 3'b000, 3'b000, 1, 0, 0, "kis_g");
    cyc(0, 3'b001, 3'b001, 1, 0, BEEF, 1, 3'b000, 3'b000, 0, 0, -1, "kis_kill");
    cyc(0, 3'b011, 3'b000, 1, 0, BEEF, 1, 3'b001, 3'b000, 1, 0, 0, "kis_ptr");
    cyc(0, 3'b000, 3'b000, 0, 1, BEEF, 1, 3'b000, 3'b001, 0, 0, -1, "kis_rsp");

    // Kill in WAIT_RSP with coincident response; next grant goes to 1.
    do_reset();
    cyc(0, 3'b001, 3'b000, 1, 0, BEEF, 1, 3'b001, 3'b000, 1, 0, 0, "kw_g");
    cyc(0, 3'b001, 3'b001, 0, 1, BEEF, 1, 3'b000, 3'b000, 0, 1, -1, "kw_kill");
    cyc(0, 3'b011, 3'b000, 1, 0, BEEF, 1, 3'b010, 3'b000, 1, 0, 1, "kw_next");
    cyc(0, 3'b000, 3'b000, 0, 1, BEEF, 1, 3'b000, 3'b010, 0, 0, -1, "kw_rsp");

    // Reset in WAIT_RSP: silent during and after, then requester 2 granted.
    cyc(0, 3'b001, 3'b000, 1, 0, BEEF, 1, 3'b001, 3'b000, 1, 0, 0, "rw_g");
    cyc(1, 3'b111, 3'b111, 1, 1, BEEF, 1, 3'b000, 3'b000, 0, 0, -1, "rw_rst");
    cyc(0, 3'b100, 3'b000, 1, 1, BEEF, 1, 3'b000, 3'b000, 0, 0, -1, "rw_after");
    cyc(0, 3'b100, 3'b000, 1, 0, BEEF, 1, 3'b100, 3'b000, 1, 0, 2, "rw_req2");
    cyc(0, 3'b000, 3'b000, 0, 1, BEEF, 1, 3'b000, 3'b100, 0, 0, -1, "rw_rsp");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] v, k;
      for (int i = 0; i < NREQ; i++) begin
        t_addr[i]  = {$urandom, $urandom};
        t_wdata[i] = {$urandom, $urandom};
        t_be[i]    = 8'($urandom);
        t_size[i]  = 2'($urandom);
        t_we[i]    = 1'($urandom);
      end
      v = 3'($urandom);
      k = '0;
      for (int i = 0; i < NREQ; i++) k[i] = ($urandom_range(0, 7) == 0);
      cyc(($urandom_range(0, 99) == 0), v, k, 1'($urandom), ($urandom_range(0, 9) < 4),
          {$urandom, $urandom}, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
